uart_tx_arb: RTL and testbench

- Packet-atomic round-robin arbiter that shares the single TX FIFO push port (and so the TX UART) among N byte-stream requesters, e.g. RX echo path, watch report, stopwatch report.
- Sits between the requesters and the TX FIFO write side.
- Once granted, a requester owns the port until its last byte is accepted, so messages never interleave.
- A starvation watchdog reclaims the port from a requester that stalls mid-packet.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arb_if.sv | 27 ++
 rtl/uart_tx_arb_rr_pick.sv | 27 ++
 rtl/uart_tx_arb.sv | 122 ++++++++++++
 tb/tb_uart_tx_arb.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART-subsystem definitions: arbiter FSM encoding, byte width and the
// default watchdog timeout also used by the watch/stopwatch message generators.
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 1_000_000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side byte streams plus TX FIFO write side of the TX arbiter.
// master = requesters/FIFO environment, slave = the arbiter itself.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 3
);

    logic [N_REQ-1:0]        req_valid;
    logic [BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_full;
    logic                    tx_push;
    logic [BYTE_W-1:0]       tx_wdata;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_push, tx_wdata
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_push, tx_wdata
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request scanning from i_ptr upward,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_winner,
    output logic         o_any
);

    // Wrapped candidates below the pointer are applied first so any hit at or
    // above the pointer overrides them; descending loops leave the lowest index.
    always_comb begin
        o_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k] && (k < int'(i_ptr))) o_winner = W'(k);
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k] && (k >= int'(i_ptr))) o_winner = W'(k);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter sharing one TX FIFO push port among N_REQ
// byte streams, with a watchdog that reclaims the port from a stalled owner.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_tx_arb_if.slave             bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     abort
);

    localparam int GID_W = $clog2(N_REQ);

    arb_state_t       r_state;
    logic [GID_W-1:0] r_grant_id;
    logic [GID_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_abort;

    logic [GID_W-1:0]  w_winner;
    logic [GID_W-1:0]  w_next_ptr;
    logic              w_any;
    logic              w_busy;
    logic              w_vld_g;
    logic              w_last_g;
    logic [BYTE_W-1:0] w_data_g;
    logic              w_fire;
    logic              w_wd_expire;
    logic [N_REQ-1:0]  w_ready;

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .i_req    (bus.req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Owner's lane select; an explicit mux keeps non-power-of-two N_REQ safe.
    always_comb begin
        w_vld_g  = 1'b0;
        w_last_g = 1'b0;
        w_data_g = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant_id == GID_W'(k)) begin
                w_vld_g  = bus.req_valid[k];
                w_last_g = bus.req_last[k];
                w_data_g = bus.req_data[BYTE_W*k +: BYTE_W];
            end
        end
    end

    assign w_busy      = (r_state == ST_BUSY);
    assign w_fire      = w_busy & w_vld_g & ~bus.tx_full;
    assign w_wd_expire = (r_wd_cnt == CNT_W'(TIMEOUT - 1));
    assign w_next_ptr  = (r_grant_id == GID_W'(N_REQ - 1)) ? '0 : r_grant_id + GID_W'(1);

    always_comb begin
        w_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_ready[k] = w_fire & (r_grant_id == GID_W'(k));
        end
    end

    assign bus.tx_push   = w_fire;
    assign bus.req_ready = w_ready;
    assign bus.tx_wdata  = w_busy ? w_data_g : '0;

    assign busy     = w_busy;
    assign grant_id = r_grant_id;
    assign abort    = r_abort;

    // Backpressure (owner valid but FIFO full) holds the watchdog, so only a
    // silent owner can ever be aborted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_wd_cnt   <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_winner;
                        r_wd_cnt   <= '0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_fire) begin
                        r_wd_cnt <= '0;
                        if (w_last_g) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end else if (!w_vld_g) begin
                        if (w_wd_expire) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= w_next_ptr;
                            r_abort  <= 1'b1;
                            r_wd_cnt <= '0;
                        end else begin
                            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed scoreboard bench for uart_tx_arb: requesters replay queued packets,
// every accepted byte is checked against the expected grant/data order.
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] grant_id;
    logic       abort;

    uart_tx_arb_if #(.N_REQ(N)) bus ();

    uart_tx_arb #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         abort_cnt = 0;
    int         abort_cyc = -1;
    logic [1:0] abort_gid = 2'd0;
    logic [N-1:0] en;
    logic [8:0] src_q [N][$];   // {last, data} per requester
    logic [9:0] exp_q [$];      // {grant id, data} in expected push order
    int         push_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Idle lanes carry junk data and a stray last flag, which must be ignored.
    task automatic drive();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < N; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                v = v | (N'(1) << k);
                if (src_q[k][0][8]) l = l | (N'(1) << k);
                d = d | ((8*N)'(src_q[k][0][7:0]) << (8*k));
            end else begin
                l = l | (N'(1) << k);
                d = d | ((8*N)'(8'hEE) << (8*k));
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic step();
        logic [9:0] e;
        @(negedge clk);
        if (abort === 1'b1) begin
            abort_cnt++;
            abort_cyc = cyc;
            abort_gid = grant_id;
        end
        if (bus.tx_push === 1'b1) begin
            push_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_push", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("push_byte", {22'd0, grant_id, bus.tx_wdata}, {22'd0, e});
                chk("push_ready", 32'(bus.req_ready), 32'd1 << e[9:8]);
            end
            for (int k = 0; k < N; k++) begin
                if (((bus.req_ready >> k) & N'(1)) != '0 && src_q[k].size() > 0)
                    void'(src_q[k].pop_front());
            end
        end else begin
            chk("ready_quiet", 32'(bus.req_ready), 32'd0);
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t0;
        int f;
        int np;
        int ab0;
        int offs [6];
        offs = '{1, 2, 4, 5, 7, 8};

        // Reset with requester 1 already holding "OK\n"
        rst = 1'b0;
        en  = 3'b010;
        bus.tx_full = 1'b0;
        src_q[1].push_back({1'b0, 8'h4F});
        src_q[1].push_back({1'b0, 8'h4B});
        src_q[1].push_back({1'b1, 8'h0A});
        exp_q.push_back({2'd1, 8'h4F});
        exp_q.push_back({2'd1, 8'h4B});
        exp_q.push_back({2'd1, 8'h0A});
        drive();
        step();
        step();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_gid",   32'(grant_id), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_push",  32'(bus.tx_push), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wdata", 32'(bus.tx_wdata), 32'd0);

        // Single requester: 1 arbitration cycle then 3 back-to-back pushes
        rst = 1'b1;
        #1;
        t0 = cyc;
        push_cyc.delete();
        chk("s1_idle_push", 32'(bus.tx_push), 32'd0);
        step();
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_gid",  32'(grant_id), 32'd1);
        step();
        step();
        step();
        chk("s1_done_idle", 32'(busy), 32'd0);
        chk("s1_push_cnt", 32'(push_cyc.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("s1_push_cyc", 32'(push_cyc[i] - t0), 32'(i + 1));

        // rr_ptr is now 2: req2 beats req0, then wraps to req0
        src_q[0].push_back({1'b1, 8'h30});
        src_q[2].push_back({1'b1, 8'h32});
        exp_q.push_back({2'd2, 8'h32});
        exp_q.push_back({2'd0, 8'h30});
        en = 3'b101;
        drive();
        #1;
        drain("s1b_drain", 20);

        // Contention from reset: service order 0,1,2 with one idle cycle between packets
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_q[k].push_back({1'b0, 8'hA0 + 8'(k)});
            src_q[k].push_back({1'b1, 8'hB0 + 8'(k)});
            exp_q.push_back({2'(k), 8'hA0 + 8'(k)});
            exp_q.push_back({2'(k), 8'hB0 + 8'(k)});
        end
        en = 3'b111;
        drive();
        #1;
        step();
        rst = 1'b1;
        #1;
        t0 = cyc;
        ab0 = abort_cnt;
        push_cyc.delete();
        drain("s2_drain", 40);
        chk("s2_push_cnt", 32'(push_cyc.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("s2_push_cyc", 32'(push_cyc[i] - t0), 32'(offs[i]));
        chk("s2_no_abort", 32'(abort_cnt), 32'(ab0));

        // Backpressure longer than TIMEOUT must not abort
        src_q[0].push_back({1'b0, 8'h61});
        src_q[0].push_back({1'b0, 8'h62});
        src_q[0].push_back({1'b0, 8'h63});
        src_q[0].push_back({1'b1, 8'h64});
        exp_q.push_back({2'd0, 8'h61});
        exp_q.push_back({2'd0, 8'h62});
        exp_q.push_back({2'd0, 8'h63});
        exp_q.push_back({2'd0, 8'h64});
        en = 3'b001;
        drive();
        #1;
        ab0 = abort_cnt;
        step();
        step();
        bus.tx_full = 1'b1;
        #1;
        np = push_cyc.size();
        repeat (20) step();
        chk("s3_no_push", 32'(push_cyc.size()), 32'(np));
        chk("s3_busy", 32'(busy), 32'd1);
        chk("s3_no_abort", 32'(abort_cnt), 32'(ab0));
        bus.tx_full = 1'b0;
        #1;
        drain("s3_drain", 20);
        chk("s3_no_abort_end", 32'(abort_cnt), 32'(ab0));
        chk("s3_idle", 32'(busy), 32'd0);

        // Watchdog: req2 stalls after one byte; req0 waits and wins after the abort
        src_q[2].push_back({1'b0, 8'h55});
        exp_q.push_back({2'd2, 8'h55});
        en = 3'b100;
        drive();
        #1;
        ab0 = abort_cnt;
        step();
        step();
        f = push_cyc[push_cyc.size() - 1];
        repeat (3) step();
        src_q[0].push_back({1'b1, 8'hA5});
        en = 3'b101;
        drive();
        #1;
        while (cyc < f + TO + 1) step();
        src_q[2].push_back({1'b1, 8'hB2});
        exp_q.push_back({2'd0, 8'hA5});
        exp_q.push_back({2'd2, 8'hB2});
        drive();
        #1;
        chk("s4_abort_now", 32'(abort), 32'd1);
        chk("s4_abort_gid", 32'(grant_id), 32'd2);
        chk("s4_abort_idle", 32'(busy), 32'd0);
        step();
        chk("s4_abort_cyc", 32'(abort_cyc - f), 32'(TO + 1));
        chk("s4_abort_gid_smp", 32'(abort_gid), 32'd2);
        drain("s4_drain", 20);
        chk("s4_abort_once", 32'(abort_cnt), 32'(ab0 + 1));

        // Reset during the 2nd byte of a 4-byte packet
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b0, 8'h13});
        src_q[1].push_back({1'b1, 8'h14});
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd1, 8'h12});
        en = 3'b010;
        drive();
        #1;
        step();
        step();
        rst = 1'b0;
        #1;
        step();
        rst = 1'b1;
        src_q[0].push_back({1'b1, 8'hC0});
        en = 3'b011;
        drive();
        #1;
        chk("s5_push",  32'(bus.tx_push), 32'd0);
        chk("s5_busy",  32'(busy), 32'd0);
        chk("s5_gid",   32'(grant_id), 32'd0);
        chk("s5_abort", 32'(abort), 32'd0);
        exp_q.push_back({2'd0, 8'hC0});
        exp_q.push_back({2'd1, 8'h13});
        exp_q.push_back({2'd1, 8'h14});
        drain("s5_drain", 20);

        // FIFO full exactly on the last byte
        src_q[2].push_back({1'b0, 8'h21});
        src_q[2].push_back({1'b1, 8'h22});
        exp_q.push_back({2'd2, 8'h21});
        exp_q.push_back({2'd2, 8'h22});
        en = 3'b100;
        drive();
        #1;
        step();
        step();
        bus.tx_full = 1'b1;
        #1;
        chk("s6_full_push", 32'(bus.tx_push), 32'd0);
        step();
        chk("s6_held", 32'(busy), 32'd1);
        bus.tx_full = 1'b0;
        #1;
        chk("s6_push_now", 32'(bus.tx_push), 32'd1);
        chk("s6_wdata", 32'(bus.tx_wdata), 32'h22);
        step();
        chk("s6_idle", 32'(busy), 32'd0);
        chk("s6_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
